// File: rtl/sdpramv_pkg.sv
// sdpramv_pkg: shared constants for the sdpramv dual-port RAM.
//   DEF_WIDTHAD / DEF_WIDTH : default address and data widths.
//   RD_LAT                  : read/ack latency in qualified edges.
// Build option: SDPRAMV_OUTREG_EN adds one output register stage (RD_LAT = 2).
package sdpramv_pkg;

    localparam int DEF_WIDTHAD = 15;
    localparam int DEF_WIDTH   = 8;

`ifdef SDPRAMV_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/sdpramv_port.sv
// sdpramv_port: output and acknowledge pipeline for one RAM port.
//   clk_i, rst_i (async, active-high), en_i (clock enable), cs_i (chip select)
//   rdata_i : word read from the array (write-first already resolved)
//   req_i   : {write request, read request}
//   q_o     : registered read data, zero when the capturing edge had cs low
//   ack_o   : registered {write ack, read ack}
// Build option: SDPRAMV_OUTREG_EN adds a second register stage to q_o and ack_o.
module sdpramv_port
    import sdpramv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cs_i,
    input  logic [WIDTH-1:0] rdata_i,
    input  logic [1:0]       req_i,
    output logic [WIDTH-1:0] q_o,
    output logic [1:0]       ack_o
);

    logic [WIDTH-1:0] q_d, q_q;
    logic [1:0]       ack_d, ack_q;

    always_comb begin
        q_d   = cs_i ? rdata_i : '0;
        ack_d = cs_i ? req_i   : 2'b00;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q   <= '0;
            ack_q <= 2'b00;
        end else if (en_i) begin
            q_q   <= q_d;
            ack_q <= ack_d;
        end
    end

`ifdef SDPRAMV_OUTREG_EN
    // Data and acks go through the same extra stage so they stay aligned.
    logic [WIDTH-1:0] q2_q;
    logic [1:0]       ack2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q2_q   <= '0;
            ack2_q <= 2'b00;
        end else if (en_i) begin
            q2_q   <= q_q;
            ack2_q <= ack_q;
        end
    end

    assign q_o   = q2_q;
    assign ack_o = ack2_q;
`else
    assign q_o   = q_q;
    assign ack_o = ack_q;
`endif

endmodule

// File: rtl/sdpramv.sv
// sdpramv: true dual-port synchronous RAM, 2**WIDTHAD words of WIDTH bits.
//   clock, reset (async, active-high), enable (global clock enable), cs (chip select)
//   Port A: address_a, wren_a, data_a -> q_a
//   Port B: address_b, wren_b, rd_b, data_b -> q_b, wr_ack_b, rd_ack_b
// Same-port read-during-write returns the new data; cross-port returns the old
// word; simultaneous writes to one address keep port A's data.
// Reset clears outputs and acks only, never the array.
// Build option: SDPRAMV_OUTREG_EN selects read latency 2 instead of 1.
module sdpramv
    import sdpramv_pkg::*;
#(
    parameter int    WIDTHAD   = DEF_WIDTHAD,
    parameter int    WIDTH     = DEF_WIDTH,
    parameter string INIT_FILE = ""
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               cs,
    input  logic [WIDTHAD-1:0] address_a,
    input  logic               wren_a,
    input  logic [WIDTH-1:0]   data_a,
    output logic [WIDTH-1:0]   q_a,
    input  logic [WIDTHAD-1:0] address_b,
    input  logic               wren_b,
    input  logic               rd_b,
    input  logic [WIDTH-1:0]   data_b,
    output logic [WIDTH-1:0]   q_b,
    output logic               wr_ack_b,
    output logic               rd_ack_b
);

    localparam int DEPTH = 2 ** WIDTHAD;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic [1:0]       ack_a_unused;

    // Power-up image of the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (enable && cs && !reset) begin
            if (wren_b) mem[address_b] <= data_b;
            if (wren_a) mem[address_a] <= data_a;
        end
    end

    // Own-port write bypasses the array; the other port's write is not seen.
    always_comb begin
        rdata_a = (wren_a && cs) ? data_a : mem[address_a];
        rdata_b = (wren_b && cs) ? data_b : mem[address_b];
    end

    sdpramv_port #(.WIDTH(WIDTH)) u_port_a (
        .clk_i   (clock),
        .rst_i   (reset),
        .en_i    (enable),
        .cs_i    (cs),
        .rdata_i (rdata_a),
        .req_i   (2'b00),
        .q_o     (q_a),
        .ack_o   (ack_a_unused)
    );

    sdpramv_port #(.WIDTH(WIDTH)) u_port_b (
        .clk_i   (clock),
        .rst_i   (reset),
        .en_i    (enable),
        .cs_i    (cs),
        .rdata_i (rdata_b),
        .req_i   ({wren_b, rd_b}),
        .q_o     (q_b),
        .ack_o   ({wr_ack_b, rd_ack_b})
    );

endmodule

// File: tb/tb_sdpramv.sv
module tb_sdpramv;

`ifdef SDPRAMV_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int AW = 15;
    localparam int DW = 8;

    typedef struct {
        bit          en;
        bit          cs;
        logic [AW-1:0] aa;
        bit          wa;
        logic [DW-1:0] da;
        logic [AW-1:0] ab;
        bit          wb;
        bit          rb;
        logic [DW-1:0] db;
        logic [DW-1:0] eqa;
        logic [DW-1:0] eqb;
        bit          ewack;
        bit          erack;
    } vec_t;

    typedef struct {
        string         nm;
        logic [DW-1:0] qa;
        logic [DW-1:0] qb;
        logic          wack;
        logic          rack;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset, enable, cs;
    logic [AW-1:0] address_a, address_b;
    logic          wren_a, wren_b, rd_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] q_a, q_b;
    logic          wr_ack_b, rd_ack_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mdl [2**AW];
    exp_t          sbq [$];
    exp_t          last_exp;
    vec_t          tab [15];

    sdpramv dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .cs        (cs),
        .address_a (address_a),
        .wren_a    (wren_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .address_b (address_b),
        .wren_b    (wren_b),
        .rd_b      (rd_b),
        .data_b    (data_b),
        .q_b       (q_b),
        .wr_ack_b  (wr_ack_b),
        .rd_ack_b  (rd_ack_b)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(bit en, bit cs_v, int aa, bit wa, int da, int ab, bit wb, bit rb,
                                int db, int eqa, int eqb, bit ewack, bit erack);
        vec_t v;
        v.en = en; v.cs = cs_v; v.aa = AW'(aa); v.wa = wa; v.da = DW'(da);
        v.ab = AW'(ab); v.wb = wb; v.rb = rb; v.db = DW'(db);
        v.eqa = DW'(eqa); v.eqb = DW'(eqb); v.ewack = ewack; v.erack = erack;
        return v;
    endfunction

    task automatic check(input exp_t e);
        n_assert++;
        if (q_a !== e.qa || q_b !== e.qb || wr_ack_b !== e.wack || rd_ack_b !== e.rack) begin
            n_fail++;
            $display("FAIL %s: got q_a=%h q_b=%h wr_ack_b=%b rd_ack_b=%b, required q_a=%h q_b=%h wr_ack_b=%b rd_ack_b=%b",
                     e.nm, q_a, q_b, wr_ack_b, rd_ack_b, e.qa, e.qb, e.wack, e.rack);
        end
    endtask

    task automatic sb_restart();
        exp_t z;
        z.nm = "post_reset"; z.qa = '0; z.qb = '0; z.wack = 1'b0; z.rack = 1'b0;
        sbq.delete();
        for (int i = 0; i < LAT - 1; i++) sbq.push_back(z);
        last_exp = z;
    endtask

    // One clock edge with vector v. Expected values come from the table
    // (use_tab) or from the behavioural memory model.
    task automatic step(input vec_t v, input bit use_tab, input string nm);
        exp_t et, em;
        enable = v.en; cs = v.cs;
        address_a = v.aa; wren_a = v.wa; data_a = v.da;
        address_b = v.ab; wren_b = v.wb; rd_b = v.rb; data_b = v.db;
        et.nm = nm; et.qa = v.eqa; et.qb = v.eqb; et.wack = v.ewack; et.rack = v.erack;
        em.nm = nm;
        em.qa   = v.cs ? (v.wa ? v.da : mdl[v.aa]) : '0;
        em.qb   = v.cs ? (v.wb ? v.db : mdl[v.ab]) : '0;
        em.wack = v.wb & v.cs;
        em.rack = v.rb & v.cs;
        @(posedge clock);
        if (v.en && v.cs) begin
            if (v.wb) mdl[v.ab] = v.db;
            if (v.wa) mdl[v.aa] = v.da;
        end
        #1;
        if (v.en) begin
            sbq.push_back(use_tab ? et : em);
            while (sbq.size() > LAT - 1) begin
                last_exp = sbq.pop_front();
                check(last_exp);
            end
        end else begin
            last_exp.nm = {nm, "_hold"};
            check(last_exp);
        end
    endtask

    task automatic check_zero(input string nm);
        exp_t z;
        z.nm = nm; z.qa = '0; z.qb = '0; z.wack = 1'b0; z.rack = 1'b0;
        check(z);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 2**AW; i++) mdl[i] = '0;

        //              en cs aa      wa da    ab      wb rb db    eqa   eqb   wk rk
        tab[0]  = mk(1, 1, 'h0010, 1, 'h5A, 'h0020, 0, 1, 'h00, 'h5A, 'h00, 0, 1);
        tab[1]  = mk(1, 1, 'h0010, 0, 'h00, 'h0010, 0, 1, 'h00, 'h5A, 'h5A, 0, 1);
        tab[2]  = mk(1, 1, 'h0020, 1, 'h11, 'h0020, 1, 0, 'h22, 'h11, 'h22, 1, 0);
        tab[3]  = mk(1, 1, 'h0020, 0, 'h00, 'h0020, 0, 1, 'h00, 'h11, 'h11, 0, 1);
        tab[4]  = mk(1, 1, 'h0000, 0, 'h00, 'h0030, 1, 0, 'h77, 'h00, 'h77, 1, 0);
        tab[5]  = mk(1, 1, 'h0030, 1, 'h33, 'h0030, 0, 1, 'h00, 'h33, 'h77, 0, 1);
        tab[6]  = mk(1, 1, 'h0030, 0, 'h00, 'h0030, 0, 1, 'h00, 'h33, 'h33, 0, 1);
        tab[7]  = mk(1, 1, 'h0040, 1, 'hC3, 'h0040, 0, 0, 'h00, 'hC3, 'h00, 0, 0);
        tab[8]  = mk(1, 0, 'h0040, 1, 'hFF, 'h0041, 1, 1, 'hEE, 'h00, 'h00, 0, 0);
        tab[9]  = mk(0, 1, 'h0040, 1, 'h99, 'h0040, 0, 1, 'h00, 'h00, 'h00, 0, 0);
        tab[10] = mk(1, 1, 'h0040, 0, 'h00, 'h0040, 0, 1, 'h00, 'hC3, 'hC3, 0, 1);
        tab[11] = mk(1, 1, 'h7FFF, 1, 'hA5, 'h0041, 0, 1, 'h00, 'hA5, 'h00, 0, 1);
        tab[12] = mk(1, 1, 'h0000, 0, 'h00, 'h7FFF, 0, 1, 'h00, 'h00, 'hA5, 0, 1);
        tab[13] = mk(1, 1, 'h7FFF, 0, 'h00, 'h0000, 1, 1, 'h3C, 'hA5, 'h3C, 1, 1);
        tab[14] = mk(1, 1, 'h0000, 0, 'h00, 'h0000, 0, 0, 'h00, 'h3C, 'h3C, 0, 0);

        reset = 1'b1; enable = 1'b1; cs = 1'b1;
        address_a = '0; wren_a = 1'b0; data_a = '0;
        address_b = '0; wren_b = 1'b0; rd_b = 1'b1; data_b = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        sb_restart();

        for (int i = 0; i < 15; i++) step(tab[i], 1'b1, $sformatf("vec%0d", i));

        // Held read request: ack stays high one edge per request edge.
        v = mk(1, 1, 'h0010, 0, 0, 'h0010, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(v, 1'b0, $sformatf("held_rd%0d", i));

        // Reset asserted mid-read clears outputs without a clock edge.
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clock);
        #1 check_zero("reset_ignores_req");
        reset = 1'b0;
        sb_restart();
        v = mk(1, 1, 'h0020, 0, 0, 'h0010, 0, 1, 0, 0, 0, 0, 0);
        step(v, 1'b0, "after_reset_rd");
        step(v, 1'b0, "after_reset_rd2");
        v = mk(1, 1, 'h0000, 0, 0, 'h0000, 0, 0, 0, 0, 0, 0, 0);
        step(v, 1'b0, "after_reset_idle");

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 300; i++) begin
            v.en = ($urandom_range(0, 9) != 0);
            v.cs = ($urandom_range(0, 6) != 0);
            v.aa = ($urandom_range(0, 7) == 0) ? AW'(15'h7FF8 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
            v.ab = ($urandom_range(0, 7) == 0) ? AW'(15'h7FF8 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
            v.wa = $urandom_range(0, 1) == 1;
            v.wb = $urandom_range(0, 1) == 1;
            v.rb = $urandom_range(0, 1) == 1;
            v.da = DW'($urandom);
            v.db = DW'($urandom);
            step(v, 1'b0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
